ex_mdu: RTL

Multiply/divide unit in the EX stage. It consumes the instruction and the forwarded rs/rt operands that the ID/EX pipeline register delivers, and it owns the architectural HI/LO registers. It runs multi-cycle MULT/MULTU/DIV/DIVU, performs single-cycle MTHI/MTLO, and serves MFHI/MFLO reads. It exports `busy` so the hazard unit can stall any later HI/LO-touching instruction in ID.

---
 rtl/ex_mdu.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ex_mdu.sv
// ex_mdu - EX-stage multiply/divide unit owning the architectural HI/LO pair.
//
// Runs MULT/MULTU/DIV/DIVU as fixed-latency operations: the result is computed
// from the operands captured on the accepting edge, held in res_hi/res_lo, and
// committed to HI/LO when the busy counter expires. MTHI/MTLO write in one edge
// with no busy period. rd_data serves MFHI/MFLO combinationally.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous, active-high; clears HI/LO and drops any pending op
//   start    in   EX holds a valid MDU operation this cycle
//   mdu_op   in   0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 none
//   cancel   in   EX instruction is being flushed; suppresses start only
//   a, b     in   forwarded rs / rt operands
//   rd_sel   in   0 selects LO, 1 selects HI on rd_data
//   busy     out  multi-cycle operation in flight
//   hi, lo   out  architectural HI / LO registers
//   rd_data  out  rd_sel ? hi : lo (zero latency)
module ex_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic        cancel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        rd_sel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic { IDLE, RUN } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic               div_zero;

    // Signed divide done on magnitudes so that -2^31 / -1 needs no special
    // case: |−2^31| fits in 32 unsigned bits and the quotient re-wraps to
    // 0x80000000. Returns {remainder, quotient}. A zero divisor is replaced
    // by 1 only to keep the operator defined; the result is discarded anyway.
    function automatic logic [63:0] div_signed(input logic signed [31:0] n,
                                               input logic signed [31:0] d);
        logic [31:0] nm;
        logic [31:0] dm;
        logic [31:0] q;
        logic [31:0] r;
        nm = n[31] ? (~n + 32'd1) : n;
        dm = d[31] ? (~d + 32'd1) : d;
        if (dm == 32'd0) dm = 32'd1;
        q = nm / dm;
        r = nm % dm;
        if (n[31] ^ d[31]) q = ~q + 32'd1;
        if (n[31])         r = ~r + 32'd1;
        return {r, q};
    endfunction

    function automatic logic [63:0] div_unsigned(input logic [31:0] n,
                                                 input logic [31:0] d);
        logic [31:0] dm;
        dm = (d == 32'd0) ? 32'd1 : d;
        return {n % dm, n / dm};
    endfunction

    logic signed [63:0] sa_p0;
    logic signed [63:0] sb_p0;
    logic signed [63:0] prod_s_p0;
    logic        [63:0] prod_u_p0;
    logic        [63:0] quo_s_p0;
    logic        [63:0] quo_u_p0;
    logic        [63:0] result_p0;
    logic               accept;
    logic               is_long;

    always_comb begin
        sa_p0     = {{32{a[31]}}, a};
        sb_p0     = {{32{b[31]}}, b};
        prod_s_p0 = sa_p0 * sb_p0;
        prod_u_p0 = {32'd0, a} * {32'd0, b};
        quo_s_p0  = div_signed(a, b);
        quo_u_p0  = div_unsigned(a, b);
        case (mdu_op)
            OP_MULT:  result_p0 = prod_s_p0;
            OP_MULTU: result_p0 = prod_u_p0;
            OP_DIV:   result_p0 = quo_s_p0;
            OP_DIVU:  result_p0 = quo_u_p0;
            default:  result_p0 = 64'd0;
        endcase
    end

    assign accept  = start & ~cancel & ~busy;
    assign is_long = (mdu_op >= OP_MULT) && (mdu_op <= OP_DIVU);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            res_hi   <= 32'd0;
            res_lo   <= 32'd0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_long) begin
                            res_hi   <= result_p0[63:32];
                            res_lo   <= result_p0[31:0];
                            div_zero <= (mdu_op == OP_DIV || mdu_op == OP_DIVU) && (b == 32'd0);
                            cnt      <= (mdu_op == OP_MULT || mdu_op == OP_MULTU)
                                        ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                            busy     <= 1'b1;
                            state    <= RUN;
                        end else if (mdu_op == OP_MTHI) begin
                            hi <= a;
                        end else if (mdu_op == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                RUN: begin
                    // cancel is deliberately ignored here: the owning
                    // instruction has already left EX and is committed.
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                        if (!div_zero) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rd_data = rd_sel ? hi : lo;

endmodule
